stm_reg_sequencer: RTL and testbench
====================================

// Module: stm_reg_sequencer
// PURPOSE
// - Multi-cycle reader of the 16x32 register file for ARM STM (block store).
// - Walks a 16-bit register list from lowest to highest index, drives the register file read port,
//   and issues one word store per listed register to the data-memory port.
// - Sits in the MEM stage and stalls the pipeline while active.
// - Returns the written-back base value on completion.
// PARAMETERS
// - WordLen   32  data/address width
// - WordCount 16  register count; list width; read-index width is log2(WordCount) = 4
// PORTS
// - clk        in   1   clock; all state updates on posedge (register file writes on negedge)
// - rst        in   1   reset, synchronous, active-high
// - start      in   1   1-cycle request; sampled only in IDLE
// - regList    in   16  bit i = store Ri; sampled with start
// - baseAddr   in   32  Rn value; sampled with start
// - pBit       in   1   1 = before (pre-index), 0 = after; sampled with start
// - uBit       in   1   1 = increment, 0 = decrement; sampled with start
// - readReg    out  4   register file read index (combinational read, same-cycle data)
// - readData   in   32  register file data for readReg
// - memWrite   out  1   store request; held until memReady
// - memAddr    out  32  word address of current store
// - memWData   out  32  store data; equals readData while memWrite=1
// - memReady   in   1   memory accepts store this cycle when memWrite&memReady
// - busy       out  1   high from cycle after accepted start through DONE; drives pipeline stall
// - done       out  1   1-cycle pulse in DONE
// - newBase    out  32  writeback value for Rn; valid while done=1
// BEHAVIOUR
// Reset:
// - state=IDLE; readReg=0, memWrite=0, memAddr=0, memWData=0, busy=0, done=0, newBase=0.
// FSM (IDLE -> SETUP -> STORE -> DONE -> IDLE):
// - IDLE: on start, latch list/base/p/u; go to SETUP.
// - SETUP, 1 cycle: n=popcount(list).
//     start address (values mod 2^32):
//       IA = base
//       IB = base+4
//       DA = base-4n+4
//       DB = base-4n
//     newBase = u ? base+4n : base-4n
//   - n==0: skip STORE; go to DONE.
// - STORE:
//   - readReg = lowest set bit of remaining list; memAddr = current address; memWrite=1.
//   - On memReady: clear that bit, addr += 4.
//   - Last bit accepted -> DONE.
//   - Without memReady: hold readReg/memAddr/memWrite unchanged.
// - DONE, 1 cycle: done=1, busy stays 1; then IDLE with busy=0.
// Ordering and timing:
// - Registers are always stored in ascending index order at ascending addresses (all four modes).
// - Latency with memReady tied high: n+2 cycles from start to done (n=0: 2 cycles).
// Boundaries:
// - start while not IDLE is ignored.
// - R15 in list: stored value is whatever the register file returns.
// - R0 is stored normally: the register file reads R0 normally.
// - Address wrap past 0xFFFFFFFC wraps modulo 2^32; no fault.
// - Reset mid-STORE: memWrite drops the cycle after the rst edge, list discarded, no done pulse.
// - Register file writes in the same cycle affect readData: store data is sampled only at the
//   accepting posedge.
// STRUCTURE
// - Shared package / header:
//   - FSM state encodings (IDLE=0, SETUP=1, STORE=2, DONE=3)
//   - addressing-mode constants {p,u}: DA=00, IA=01, DB=10, IB=11
//   - WORD_BYTES=4
// - Sub-module reg_list_pri_enc: 16-bit list -> 4-bit lowest-set index + valid; combinational.
// - Popcount and address arithmetic stay inline.
// TESTING
// - IA: base=0x100, list=0x000B, memReady=1 ->
//     stores R0@0x100, R1@0x104, R3@0x108; newBase=0x10C; done at cycle 5.
// - DB: base=0x200, list=0x8001 -> R0@0x1F8, R15@0x1FC; newBase=0x1F8.
// - Backpressure: IB, base=0x40, list=0x0006, memReady low for 3 cycles on first store ->
//     memWrite/memAddr=0x44/readReg=1 held stable; R2 stored @0x48 after.
// - Empty list: list=0 -> no memWrite; done 2 cycles after start; newBase=base.
// - Reset mid-op: list=0xFFFF, assert rst after 4th accepted store ->
//     memWrite=0 and busy=0 next cycle; no done.
//   - Start ignored while busy.
// - Wrap: IA, base=0xFFFFFFF8, list=0x0007 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.

Source files
------------

// File: rtl/stm_reg_sequencer_pkg.sv
// Shared definitions for the STM block-store sequencer.
//   - FSM state encoding
//   - addressing-mode codes, indexed as {p, u}
//   - word geometry (data width, register count, bytes per word)
package stm_reg_sequencer_pkg;

    localparam int WORD_LEN   = 32;
    localparam int WORD_COUNT = 16;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_STORE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // {p, u}: p = pre-index (before), u = increment
    localparam logic [1:0] MODE_DA = 2'b00;
    localparam logic [1:0] MODE_IA = 2'b01;
    localparam logic [1:0] MODE_DB = 2'b10;
    localparam logic [1:0] MODE_IB = 2'b11;

endpackage

// File: rtl/stm_reg_sequencer_reg_list_pri_enc.sv
// Lowest-set-bit priority encoder for an STM register list.
// Ports:
//   list_i   in   WordCount  register list (bit i = Ri)
//   idx_o    out  IdxW       index of the lowest set bit (0 when list is empty)
//   valid_o  out  1          list has at least one bit set
module reg_list_pri_enc
    import stm_reg_sequencer_pkg::*;
#(
    parameter  int WordCount = WORD_COUNT,
    localparam int IdxW      = $clog2(WordCount)
) (
    input  logic [WordCount-1:0] list_i,
    output logic [IdxW-1:0]      idx_o,
    output logic                 valid_o
);

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = WordCount - 1; i >= 0; i--) begin
            if (list_i[i]) begin
                idx_o   = i[IdxW-1:0];
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stm_reg_sequencer.sv
// Multi-cycle register-file reader for ARM STM (block store).
// Walks the latched register list from lowest to highest index, reads each
// listed register through the register-file read port and issues one word
// store per register. Stalls the pipeline (busy) while active and returns
// the written-back base value with the one-cycle done pulse.
//
// Ports:
//   clk       in   1        clock, posedge
//   rst       in   1        synchronous active-high reset
//   start     in   1        request, sampled only in IDLE
//   regList   in   16       bit i = store Ri
//   baseAddr  in   32       Rn value
//   pBit      in   1        1 = pre-index, 0 = post-index
//   uBit      in   1        1 = increment, 0 = decrement
//   readReg   out  4        register-file read index
//   readData  in   32       register-file data for readReg (same cycle)
//   memWrite  out  1        store request, held until memReady
//   memAddr   out  32       word address of current store
//   memWData  out  32       store data (readData while memWrite)
//   memReady  in   1        store accepted when memWrite & memReady
//   busy      out  1        pipeline stall, SETUP through DONE
//   done      out  1        one-cycle completion pulse
//   newBase   out  32       Rn writeback value, valid with done
//
// state  | meaning
// IDLE   | waiting for start; operands latched on start
// SETUP  | count list, compute first address and new base
// STORE  | one store per listed register, ascending index and address
// DONE   | done pulse with newBase, then back to IDLE
module stm_reg_sequencer
    import stm_reg_sequencer_pkg::*;
#(
    parameter  int WordLen   = WORD_LEN,
    parameter  int WordCount = WORD_COUNT,
    localparam int IdxW      = $clog2(WordCount)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WordCount-1:0] regList,
    input  logic [WordLen-1:0]   baseAddr,
    input  logic                 pBit,
    input  logic                 uBit,
    output logic [IdxW-1:0]      readReg,
    input  logic [WordLen-1:0]   readData,
    output logic                 memWrite,
    output logic [WordLen-1:0]   memAddr,
    output logic [WordLen-1:0]   memWData,
    input  logic                 memReady,
    output logic                 busy,
    output logic                 done,
    output logic [WordLen-1:0]   newBase
);

    localparam int CntW = IdxW + 1;

    state_t               state_q, state_d;
    logic [WordCount-1:0] list_q, list_d;
    logic [WordLen-1:0]   base_q, base_d;
    logic [WordLen-1:0]   addr_q, addr_d;
    logic [WordLen-1:0]   newbase_q, newbase_d;
    logic                 p_q, p_d;
    logic                 u_q, u_d;

    logic [IdxW-1:0]      enc_idx;
    logic                 enc_valid;
    logic [CntW-1:0]      cnt;
    logic [WordLen-1:0]   offset;
    logic [WordLen-1:0]   step;
    logic [WordCount-1:0] clr_mask;

    reg_list_pri_enc #(
        .WordCount (WordCount)
    ) u_pri_enc (
        .list_i  (list_q),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WordCount; i++) begin
            cnt = cnt + CntW'(list_q[i]);
        end
    end

    assign step   = WordLen'(WORD_BYTES);
    assign offset = WordLen'(cnt) * step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            list_q    <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            newbase_q <= '0;
            p_q       <= 1'b0;
            u_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            list_q    <= list_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            newbase_q <= newbase_d;
            p_q       <= p_d;
            u_q       <= u_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        list_d    = list_q;
        base_d    = base_q;
        addr_d    = addr_q;
        newbase_d = newbase_q;
        p_d       = p_q;
        u_d       = u_q;
        clr_mask  = '0;
        memWrite  = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    list_d  = regList;
                    base_d  = baseAddr;
                    p_d     = pBit;
                    u_d     = uBit;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // Every mode stores ascending registers at ascending
                // addresses; only the lowest address of the block differs.
                unique case ({p_q, u_q})
                    MODE_IA: addr_d = base_q;
                    MODE_IB: addr_d = base_q + step;
                    MODE_DA: addr_d = base_q - offset + step;
                    default: addr_d = base_q - offset;
                endcase
                newbase_d = u_q ? (base_q + offset) : (base_q - offset);
                state_d   = (cnt == '0) ? ST_DONE : ST_STORE;
            end
            ST_STORE: begin
                memWrite = enc_valid;
                if (enc_valid && memReady) begin
                    clr_mask[enc_idx] = 1'b1;
                    list_d = list_q & ~clr_mask;
                    addr_d = addr_q + step;
                    if (list_d == '0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign readReg  = (state_q == ST_STORE) ? enc_idx : '0;
    assign memAddr  = (state_q == ST_STORE) ? addr_q : '0;
    assign memWData = memWrite ? readData : '0;
    assign newBase  = newbase_q;

endmodule

// File: tb/tb_stm_reg_sequencer.sv
module tb_stm_reg_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] regList;
    logic [31:0] baseAddr;
    logic        pBit, uBit;
    logic [3:0]  readReg;
    logic [31:0] readData;
    logic        memWrite;
    logic [31:0] memAddr, memWData;
    logic        memReady;
    logic        busy, done;
    logic [31:0] newBase;

    stm_reg_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .regList  (regList),
        .baseAddr (baseAddr),
        .pBit     (pBit),
        .uBit     (uBit),
        .readReg  (readReg),
        .readData (readData),
        .memWrite (memWrite),
        .memAddr  (memAddr),
        .memWData (memWData),
        .memReady (memReady),
        .busy     (busy),
        .done     (done),
        .newBase  (newBase)
    );

    always #5 clk = ~clk;

    logic [31:0] regs [16];
    assign readData = regs[readReg];

    typedef struct {
        logic [3:0]  r;
        logic [31:0] a;
        logic [31:0] d;
    } st_t;

    typedef struct {
        logic [31:0] nb;
        int          lat;
        int          scyc;
    } dn_t;

    st_t st_q[$];
    dn_t dn_q[$];
    st_t se;
    dn_t de;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int accepts  = 0;
    int dones    = 0;
    int ready_mode = 0;  // 0 = always ready, 1 = random, 2 = never ready

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // memReady driver, updated just after each rising edge
    initial begin
        memReady = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       memReady = 1'b1;
                1:       memReady = 1'($urandom_range(0, 1));
                default: memReady = 1'b0;
            endcase
        end
    end

    // Monitor: pops and compares on every accepted store and every done pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (memWrite && memReady) begin
                if (st_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_store actual=R%0d@0x%08h required=no store", readReg, memAddr);
                end else begin
                    se = st_q.pop_front();
                    chk("store_reg", 32'(readReg), 32'(se.r));
                    chk("store_addr", memAddr, se.a);
                    chk("store_data", memWData, se.d);
                end
                accepts++;
            end
            if (done) begin
                if (dn_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=done newBase=0x%08h required=no done", newBase);
                end else begin
                    de = dn_q.pop_front();
                    chk("new_base", newBase, de.nb);
                    chk("stores_left_at_done", 32'(st_q.size()), 32'd0);
                    chk("busy_in_done", 32'(busy), 32'd1);
                    if (de.lat >= 0) chk("latency", 32'(cyc - de.scyc), 32'(de.lat));
                end
                dones++;
            end
        end
    end

    // Reference model: the block occupies n consecutive words; its lowest
    // word depends on the mode, registers fill it in ascending order.
    task automatic push_model(input logic [15:0] list, input logic [31:0] base,
                              input logic p, input logic u, input int lat);
        int          n;
        int          k;
        logic [31:0] lowest;
        logic [31:0] span;
        st_t         e;
        dn_t         d;
        n    = $countones(list);
        span = 32'(4 * n);
        if (u) lowest = p ? base + 32'd4 : base;
        else   lowest = p ? base - span : base - span + 32'd4;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                e.r = 4'(i);
                e.a = lowest + 32'(4 * k);
                e.d = regs[i];
                st_q.push_back(e);
                k++;
            end
        end
        d.nb   = u ? base + span : base - span;
        d.lat  = (lat >= 0) ? n + 2 : -1;
        d.scyc = cyc;
        dn_q.push_back(d);
    endtask

    task automatic issue_op(input logic [15:0] list, input logic [31:0] base,
                            input logic p, input logic u, input int lat, input bit ign);
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        regList  = list;
        baseAddr = base;
        pBit     = p;
        uBit     = u;
        start    = 1'b1;
        push_model(list, base, p, u, lat);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (ign) begin
            regList  = 16'($urandom);
            baseAddr = $urandom;
            pBit     = 1'($urandom);
            uBit     = 1'($urandom);
            start    = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic wait_done(input int d0);
        int k;
        k = 0;
        while (dones == d0 && k < 400) begin
            @(posedge clk);
            k++;
        end
        if (dones == d0) begin
            checks++;
            failures++;
            $display("FAIL op_timeout actual=no done required=done within 400 cycles");
            st_q.delete();
            dn_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [15:0] list, input logic [31:0] base,
                          input logic p, input logic u, input int lat, input bit ign);
        int d0;
        d0 = dones;
        issue_op(list, base, p, u, lat, ign);
        wait_done(d0);
    endtask

    initial begin
        int d0;
        int k;
        int a0;
        for (int i = 0; i < 16; i++) regs[i] = 32'h0;
        rst      = 1'b1;
        start    = 1'b0;
        regList  = '0;
        baseAddr = '0;
        pBit     = 1'b0;
        uBit     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_readReg", 32'(readReg), 32'd0);
        chk("reset_memWrite", 32'(memWrite), 32'd0);
        chk("reset_memAddr", memAddr, 32'd0);
        chk("reset_memWData", memWData, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_newBase", newBase, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // IA, spec example: three stores then newBase 0x10C
        ready_mode = 0;
        run_op(16'h000B, 32'h0000_0100, 1'b0, 1'b1, 0, 1'b0);
        // DB with R0 and R15
        run_op(16'h8001, 32'h0000_0200, 1'b1, 1'b0, 0, 1'b0);
        // DA, and start during busy is ignored
        run_op(16'h00F0, 32'h0000_1000, 1'b0, 1'b0, 0, 1'b1);
        // Empty list: no store, done two cycles after start
        run_op(16'h0000, 32'h0000_0300, 1'b1, 1'b1, 0, 1'b0);
        // Address wrap
        run_op(16'h0007, 32'hFFFF_FFF8, 1'b0, 1'b1, 0, 1'b0);
        // Full list
        run_op(16'hFFFF, 32'h0000_8000, 1'b1, 1'b1, 0, 1'b0);

        // Backpressure: first store held for three cycles
        ready_mode = 2;
        d0 = dones;
        issue_op(16'h0006, 32'h0000_0040, 1'b1, 1'b1, -1, 1'b0);
        k = 0;
        @(negedge clk);
        while (!memWrite && k < 20) begin
            @(negedge clk);
            k++;
        end
        for (int h = 0; h < 3; h++) begin
            chk("hold_memWrite", 32'(memWrite), 32'd1);
            chk("hold_memAddr", memAddr, 32'h0000_0044);
            chk("hold_readReg", 32'(readReg), 32'd1);
            if (h < 2) @(negedge clk);
        end
        ready_mode = 0;
        wait_done(d0);

        // Reset after the fourth accepted store of a full list
        ready_mode = 0;
        a0 = accepts;
        issue_op(16'hFFFF, 32'h0000_2000, 1'b0, 1'b1, 0, 1'b0);
        k = 0;
        while (accepts < a0 + 4 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("accepts_before_reset", 32'(accepts - a0), 32'd4);
        ready_mode = 2;
        @(posedge clk);
        #1;
        rst = 1'b1;
        st_q.delete();
        dn_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_memWrite", 32'(memWrite), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_idle_busy", 32'(busy), 32'd0);

        // Randomized operations with random backpressure
        ready_mode = 1;
        for (int t = 0; t < 40; t++) begin
            logic [15:0] l;
            case ($urandom_range(0, 5))
                0:       l = 16'h0000;
                1:       l = 16'(1) << $urandom_range(0, 15);
                2:       l = 16'hFFFF;
                default: l = 16'($urandom);
            endcase
            run_op(l, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 1'($urandom), 1'($urandom),
                   -1, 1'($urandom));
        end

        ready_mode = 0;
        repeat (4) @(posedge clk);
        chk("final_store_queue_empty", 32'(st_q.size()), 32'd0);
        chk("final_done_queue_empty", 32'(dn_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
